gcd_issuer: RTL and testbench

- Requester-side front end for the GCD engine.
- Accepts operand pairs from an upstream valid/ready channel and short-circuits zero operands without using the engine.
- For non-zero pairs, drives the engine enable and operand lines, waits for the engine's done edge, and returns the result (or a timeout error) on a downstream valid/ready channel.
- One job in flight at a time.

---
 rtl/gcd_issuer.sv | 149 ++++++++++++++
 tb/tb_gcd_issuer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_issuer.sv
// gcd_issuer: requester-side front end for the GCD engine.
// Takes operand pairs from an upstream valid/ready channel. Pairs with a zero
// operand are answered directly. Other pairs are run on the engine, and the
// result (or a timeout error) is returned on a downstream valid/ready channel.
// Only one job is in flight at a time.
module gcd_issuer #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_gcd_o,
    output logic                  resp_err_o,
    output logic                  resp_bypass_o,
    output logic                  gcd_enable_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    input  logic [DATA_WIDTH-1:0] gcd_result_i,
    input  logic                  gcd_done_i,
    output logic                  busy_o,
    output logic [15:0]           job_count_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Timer value seen in the last permitted WAIT cycle
    localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q,     state_d;
    logic [CNT_WIDTH-1:0]  timer_q,     timer_d;
    logic [DATA_WIDTH-1:0] operand_a_q, operand_a_d;
    logic [DATA_WIDTH-1:0] operand_b_q, operand_b_d;
    logic [DATA_WIDTH-1:0] resp_gcd_q,  resp_gcd_d;
    logic                  resp_err_q,  resp_err_d;
    logic                  resp_byp_q,  resp_byp_d;
    logic [15:0]           job_cnt_q,   job_cnt_d;
    logic                  done_q;
    logic                  alive_q;
    logic                  done_rise;
    logic                  accept;

    // The engine's done is a level. Only a fresh low-to-high edge counts.
    assign done_rise = gcd_done_i & ~done_q;

    // Ready is decoded from registers only. alive_q keeps ready low while reset is asserted.
    assign req_ready_o  = (state_q == ST_IDLE) & alive_q;
    assign resp_valid_o = (state_q == ST_RESP);
    assign gcd_enable_o = (state_q == ST_LAUNCH) | (state_q == ST_WAIT);
    assign busy_o       = (state_q != ST_IDLE);
    assign accept       = req_valid_i & req_ready_o;

    assign operand_a_o   = operand_a_q;
    assign operand_b_o   = operand_b_q;
    assign resp_gcd_o    = resp_gcd_q;
    assign resp_err_o    = resp_err_q;
    assign resp_bypass_o = resp_byp_q;
    assign job_count_o   = job_cnt_q;

    // Next-state logic for the job sequencer and its response registers
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        resp_gcd_d  = resp_gcd_q;
        resp_err_d  = resp_err_q;
        resp_byp_d  = resp_byp_q;
        job_cnt_d   = job_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    operand_a_d = req_a_i;
                    operand_b_d = req_b_i;
                    if ((req_a_i == '0) || (req_b_i == '0)) begin
                        resp_gcd_d = req_a_i | req_b_i;
                        resp_err_d = 1'b0;
                        resp_byp_d = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + CNT_WIDTH'(1);
                if (done_rise) begin
                    resp_gcd_d = gcd_result_i;
                    resp_err_d = 1'b0;
                    resp_byp_d = 1'b0;
                    state_d    = ST_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    resp_gcd_d = '0;
                    resp_err_d = 1'b1;
                    resp_byp_d = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    job_cnt_d = job_cnt_q + 16'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers. A reset discards any job in flight.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            resp_gcd_q  <= '0;
            resp_err_q  <= 1'b0;
            resp_byp_q  <= 1'b0;
            job_cnt_q   <= '0;
            done_q      <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            resp_gcd_q  <= resp_gcd_d;
            resp_err_q  <= resp_err_d;
            resp_byp_q  <= resp_byp_d;
            job_cnt_q   <= job_cnt_d;
            done_q      <= gcd_done_i;
            alive_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gcd_issuer.sv
// tb_gcd_issuer: randomized and directed bench for gcd_issuer. It uses a
// behavioural engine model and a reference GCD computed by plain arithmetic.
module tb_gcd_issuer;

    localparam int TO = 8;

    logic       clk_i = 1'b0;
    logic       nreset_i;
    logic       req_valid_i, req_ready_o;
    logic [7:0] req_a_i, req_b_i;
    logic       resp_valid_o, resp_ready_i;
    logic [7:0] resp_gcd_o;
    logic       resp_err_o, resp_bypass_o, gcd_enable_o;
    logic [7:0] operand_a_o, operand_b_o, gcd_result_i;
    logic       gcd_done_i, busy_o;
    logic [15:0] job_count_o;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_jobs = 0;

    // engine model controls
    int         eng_delay   = 5;
    int         eng_drop_at = 1;
    bit         eng_never   = 0;
    bit         eng_sticky  = 0;
    logic [7:0] eng_result  = 8'd0;
    int         en_cnt      = 0;

    gcd_issuer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .nreset_i(nreset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_gcd_o(resp_gcd_o), .resp_err_o(resp_err_o), .resp_bypass_o(resp_bypass_o),
        .gcd_enable_o(gcd_enable_o), .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
        .gcd_result_i(gcd_result_i), .gcd_done_i(gcd_done_i),
        .busy_o(busy_o), .job_count_o(job_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    // Engine model: on the eng_delay-th cycle with enable high, done rises with the result
    initial begin
        gcd_done_i   = 1'b0;
        gcd_result_i = 8'd0;
        forever begin
            @(posedge clk_i);
            #1;
            if (gcd_enable_o) begin
                en_cnt++;
                if (en_cnt == eng_drop_at) gcd_done_i = 1'b0;
                if (!eng_never && en_cnt == eng_delay) begin
                    gcd_done_i   = 1'b1;
                    gcd_result_i = eng_result;
                end
            end else begin
                en_cnt = 0;
                if (!eng_sticky) gcd_done_i = 1'b0;
            end
        end
    end

    task automatic send_req(input logic [7:0] a, input logic [7:0] b, output bit accepted);
        int w = 0;
        accepted    = 0;
        req_a_i     = a;
        req_b_i     = b;
        req_valid_i = 1'b1;
        while (!req_ready_o && w < 100) begin
            @(posedge clk_i); #1; w++;
        end
        if (req_ready_o) begin
            @(posedge clk_i); #1;
            accepted = 1;
        end
        req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(output bit got, output int en_cycles, output int lat);
        got = 0; en_cycles = 0; lat = 0;
        for (int i = 0; i < 200; i++) begin
            if (resp_valid_o) begin
                got = 1;
                lat = i;
                break;
            end
            if (gcd_enable_o) en_cycles++;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic finish_resp();
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        exp_jobs++;
    endtask

    task automatic test_reset();
        nreset_i = 1'b1; req_valid_i = 1'b0; req_a_i = '0; req_b_i = '0; resp_ready_i = 1'b0;
        #2 nreset_i = 1'b0;
        #10;
        n_checks++; if ({req_ready_o, resp_valid_o, gcd_enable_o, busy_o, resp_err_o, resp_bypass_o} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000", {req_ready_o, resp_valid_o, gcd_enable_o, busy_o, resp_err_o, resp_bypass_o}); else n_pass++;
        n_checks++; if ({job_count_o, operand_a_o, operand_b_o, resp_gcd_o} !== 40'd0)
            $display("[TB] FAIL reset_data: got %h expected 0", {job_count_o, operand_a_o, operand_b_o, resp_gcd_o}); else n_pass++;
        @(negedge clk_i); nreset_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if (req_ready_o !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready_o); else n_pass++;
    endtask

    task automatic test_engine_basic();
        bit acc, got; int enc, lat;
        eng_delay = 5; eng_result = gcd_ref(8'd12, 8'd18);
        send_req(8'd12, 8'd18, acc);
        n_checks++; if (acc !== 1'b1) $display("[TB] FAIL basic_accept: got %b expected 1", acc); else n_pass++;
        wait_resp(got, enc, lat);
        n_checks++; if (got !== 1'b1) $display("[TB] FAIL basic_resp_timeout: got %b expected 1", got); else n_pass++;
        n_checks++; if ({resp_gcd_o, resp_err_o, resp_bypass_o} !== {8'd6, 2'b00})
            $display("[TB] FAIL basic_result: got %h/%b/%b expected 06/0/0", resp_gcd_o, resp_err_o, resp_bypass_o); else n_pass++;
        n_checks++; if (enc != 5) $display("[TB] FAIL basic_enable_cycles: got %0d expected 5", enc); else n_pass++;
        n_checks++; if (gcd_enable_o !== 1'b0) $display("[TB] FAIL basic_enable_in_resp: got %b expected 0", gcd_enable_o); else n_pass++;
        n_checks++; if ({operand_a_o, operand_b_o} !== {8'd12, 8'd18})
            $display("[TB] FAIL basic_operands: got %0d,%0d expected 12,18", operand_a_o, operand_b_o); else n_pass++;
        finish_resp();
        n_checks++; if (job_count_o !== 16'd1) $display("[TB] FAIL basic_job_count: got %0d expected 1", job_count_o); else n_pass++;
    endtask

    task automatic test_bypass();
        bit acc, got; int enc, lat;
        logic [7:0] bvals [2];
        bvals[0] = 8'd9; bvals[1] = 8'd0;
        for (int k = 0; k < 2; k++) begin
            send_req(8'd0, bvals[k], acc);
            wait_resp(got, enc, lat);
            n_checks++; if (!(acc && got && lat == 0))
                $display("[TB] FAIL bypass_latency: got acc=%b resp=%b lat=%0d expected 1/1/0", acc, got, lat); else n_pass++;
            n_checks++; if (enc != 0 || gcd_enable_o !== 1'b0) $display("[TB] FAIL bypass_enable: got %0d cycles expected 0", enc); else n_pass++;
            n_checks++; if ({resp_gcd_o, resp_err_o, resp_bypass_o} !== {bvals[k], 2'b01})
                $display("[TB] FAIL bypass_result: got %h/%b/%b expected %h/0/1", resp_gcd_o, resp_err_o, resp_bypass_o, bvals[k]); else n_pass++;
            finish_resp();
        end
    endtask

    task automatic test_timeout();
        bit acc, got; int enc, lat;
        // never done, then done exactly in the last WAIT cycle, then one cycle too late
        int delays [3];
        delays[0] = 0; delays[1] = TO + 1; delays[2] = TO + 2;
        for (int k = 0; k < 3; k++) begin
            eng_never  = (k == 0);
            eng_delay  = delays[k];
            eng_result = gcd_ref(8'd40, 8'd100);
            send_req(8'd40, 8'd100, acc);
            wait_resp(got, enc, lat);
            n_checks++; if (!(acc && got)) $display("[TB] FAIL timeout_resp_%0d: got acc=%b resp=%b expected 1/1", k, acc, got); else n_pass++;
            n_checks++; if (enc != TO + 1) $display("[TB] FAIL timeout_cycles_%0d: got %0d expected %0d", k, enc, TO + 1); else n_pass++;
            if (k == 1) begin
                n_checks++; if ({resp_gcd_o, resp_err_o, resp_bypass_o} !== {8'd20, 2'b00})
                    $display("[TB] FAIL timeout_edge_done: got %h/%b/%b expected 14/0/0", resp_gcd_o, resp_err_o, resp_bypass_o); else n_pass++;
            end else begin
                n_checks++; if ({resp_gcd_o, resp_err_o, resp_bypass_o} !== {8'd0, 2'b10})
                    $display("[TB] FAIL timeout_err_%0d: got %h/%b/%b expected 00/1/0", k, resp_gcd_o, resp_err_o, resp_bypass_o); else n_pass++;
            end
            finish_resp();
        end
        eng_never = 0;
    endtask

    task automatic test_backpressure();
        bit acc, got; int enc, lat;
        bit stable = 1, blocked = 1;
        logic [9:0] held;
        eng_delay = 4; eng_result = gcd_ref(8'd15, 8'd25);
        send_req(8'd15, 8'd25, acc);
        wait_resp(got, enc, lat);
        held = {resp_gcd_o, resp_err_o, resp_bypass_o};
        req_a_i = 8'd4; req_b_i = 8'd6; req_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            if ({resp_gcd_o, resp_err_o, resp_bypass_o} !== held || resp_valid_o !== 1'b1) stable = 0;
            if (req_ready_o !== 1'b0) blocked = 0;
        end
        n_checks++; if (!(got && held === {8'd5, 2'b00})) $display("[TB] FAIL bp_result: got %h expected %h", held, {8'd5, 2'b00}); else n_pass++;
        n_checks++; if (!stable) $display("[TB] FAIL bp_stable: got unstable response expected stable"); else n_pass++;
        n_checks++; if (!blocked) $display("[TB] FAIL bp_ready_low: got ready high expected low"); else n_pass++;
        finish_resp();
        n_checks++; if ({busy_o, req_ready_o} !== 2'b01) $display("[TB] FAIL bp_no_accept_on_handshake: got busy=%b ready=%b expected 0/1", busy_o, req_ready_o); else n_pass++;
        eng_result = gcd_ref(8'd4, 8'd6);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n_checks++; if ({busy_o, operand_a_o, operand_b_o} !== {1'b1, 8'd4, 8'd6})
            $display("[TB] FAIL bp_second_accept: got busy=%b a=%0d b=%0d expected 1/4/6", busy_o, operand_a_o, operand_b_o); else n_pass++;
        wait_resp(got, enc, lat);
        n_checks++; if (!(got && resp_gcd_o === 8'd2)) $display("[TB] FAIL bp_second_result: got %0d expected 2", resp_gcd_o); else n_pass++;
        finish_resp();
    endtask

    task automatic test_done_stuck();
        bit acc, got; int enc, lat;
        eng_sticky = 1; eng_delay = 4; eng_result = gcd_ref(8'd9, 8'd12);
        send_req(8'd9, 8'd12, acc);
        wait_resp(got, enc, lat);
        n_checks++; if (!(got && resp_gcd_o === 8'd3)) $display("[TB] FAIL stuck_first: got %0d expected 3", resp_gcd_o); else n_pass++;
        finish_resp();
        // done still high: drops on the 3rd enabled cycle and rises again on the 6th
        eng_drop_at = 3; eng_delay = 6; eng_result = gcd_ref(8'd7, 8'd21);
        send_req(8'd7, 8'd21, acc);
        wait_resp(got, enc, lat);
        n_checks++; if (!(got && {resp_gcd_o, resp_err_o} === {8'd7, 1'b0} && enc == 6))
            $display("[TB] FAIL stuck_new_rise: got %0d/%b after %0d expected 7/0 after 6", resp_gcd_o, resp_err_o, enc); else n_pass++;
        finish_resp();
        // done stays high for the whole job: no fresh rise, so the job times out
        eng_drop_at = 0; eng_never = 1;
        send_req(8'd7, 8'd21, acc);
        wait_resp(got, enc, lat);
        n_checks++; if (!(got && {resp_gcd_o, resp_err_o} === {8'd0, 1'b1}))
            $display("[TB] FAIL stuck_no_rise: got %0d/%b expected 0/1", resp_gcd_o, resp_err_o); else n_pass++;
        finish_resp();
        eng_sticky = 0; eng_drop_at = 1; eng_never = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_random();
        bit acc, got; int enc, lat;
        logic [7:0] a, b, eg;
        logic ee, eb;
        int eenc;
        for (int n = 0; n < 24; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            eng_delay  = $urandom_range(2, TO + 3);
            eng_result = gcd_ref(a, b);
            if (a == 0 || b == 0) begin
                eg = a | b; ee = 0; eb = 1; eenc = 0;
            end else if (eng_delay <= TO + 1) begin
                eg = gcd_ref(a, b); ee = 0; eb = 0; eenc = eng_delay;
            end else begin
                eg = 0; ee = 1; eb = 0; eenc = TO + 1;
            end
            send_req(a, b, acc);
            wait_resp(got, enc, lat);
            n_checks++; if (!(acc && got && {resp_gcd_o, resp_err_o, resp_bypass_o} === {eg, ee, eb} && enc == eenc))
                $display("[TB] FAIL random_%0d a=%0d b=%0d: got %0d/%b/%b en=%0d expected %0d/%b/%b en=%0d",
                         n, a, b, resp_gcd_o, resp_err_o, resp_bypass_o, enc, eg, ee, eb, eenc); else n_pass++;
            repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
            finish_resp();
        end
        n_checks++; if (job_count_o !== 16'(exp_jobs)) $display("[TB] FAIL random_job_count: got %0d expected %0d", job_count_o, exp_jobs); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit acc; bit spurious = 0;
        eng_never = 1;
        send_req(8'd30, 8'd45, acc);
        repeat (4) begin @(posedge clk_i); #1; end
        #2 nreset_i = 1'b0;
        #1;
        n_checks++; if ({gcd_enable_o, busy_o, resp_valid_o, req_ready_o} !== 4'b0)
            $display("[TB] FAIL midreset_outputs: got %b expected 0000", {gcd_enable_o, busy_o, resp_valid_o, req_ready_o}); else n_pass++;
        exp_jobs = 0;
        @(negedge clk_i); @(negedge clk_i); nreset_i = 1'b1;
        eng_never = 0;
        @(posedge clk_i); #1;
        n_checks++; if ({req_ready_o, busy_o} !== 2'b10) $display("[TB] FAIL midreset_idle: got ready=%b busy=%b expected 1/0", req_ready_o, busy_o); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            if (resp_valid_o !== 1'b0) spurious = 1;
            @(posedge clk_i); #1;
        end
        n_checks++; if (spurious) $display("[TB] FAIL midreset_spurious_resp: got resp_valid expected none"); else n_pass++;
        n_checks++; if (job_count_o !== 16'(exp_jobs)) $display("[TB] FAIL midreset_job_count: got %0d expected %0d", job_count_o, exp_jobs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_engine_basic();
        test_bypass();
        test_timeout();
        test_backpressure();
        test_done_stuck();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
